out_logger: RTL and testbench
=============================

OUT_LOGGER -- requirements
Module: out_logger

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the CPU output bus and of the address bus.
REQ-002 SHALL have parameter DEPTH, default 8, number of FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port out, input, DATA_W, the CPU result bus being monitored.
REQ-006 SHALL have port addr_out, input, DATA_W, the CPU program address, used as an entry tag.
REQ-007 SHALL have port rd_ready, input, 1, consumer ready.
REQ-008 SHALL have port rd_valid, output, 1, head entry available.
REQ-009 SHALL have port rd_data, output, 2*DATA_W, head entry {tag, value}, with addr_out in the upper half.
REQ-010 SHALL have port count, output, log2(DEPTH)+1, number of entries held.
REQ-011 SHALL have port full, output, 1, asserted when count == DEPTH.
REQ-012 SHALL have port empty, output, 1, asserted when count == 0.
REQ-013 SHALL have port overflow, output, 1, sticky dropped-entry flag.

Function
REQ-014 SHALL implement FSM states SEED and RUN; SEED is entered on reset, and RUN is entered after exactly one SEED cycle.
REQ-015 In SEED, the block SHALL load last_val <= out and SHALL NOT push an entry.
REQ-016 In RUN, an edge where out != last_val SHALL be a push request, with entry {addr_out, out} sampled at that edge.
REQ-017 last_val SHALL update to out on every push request, whether accepted or dropped.
REQ-018 A pop SHALL occur on an edge where rd_valid && rd_ready.
REQ-019 rd_valid SHALL equal !empty; rd_data SHALL show the head entry directly from storage (first-word fall-through), with no read latency.
REQ-020 Latency: out changes before edge N → rd_valid is high after edge N when the FIFO was empty.
REQ-021 Push on a non-full FIFO SHALL be accepted; count increments unless a pop occurs on the same edge.
REQ-022 Push with pop on the same edge SHALL be accepted even when full; count is unchanged and overflow is not set.
REQ-023 Push when full without pop SHALL drop the entry and set overflow to 1, and overflow SHALL remain 1 until rst.
REQ-024 Pop when empty SHALL be impossible, since rd_valid = 0; rd_data is don't-care when empty.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be the only full/empty discriminator.
REQ-026 rd_data SHALL be held stable while rd_valid && !rd_ready.

Reset
REQ-027 On rst = 1 at an edge, the block SHALL set state=SEED, pointers=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, and last_val=0.
REQ-028 Reset mid-operation SHALL discard all stored entries, and no push SHALL occur on the reset edge or on the following SEED edge.
REQ-029 FIFO storage contents need no reset.

Structure
REQ-030 Package out_logger_pkg SHALL hold DATA_W/DEPTH defaults, the entry width constant, and the state encoding (SEED=0, RUN=1).
REQ-031 Storage and pointers SHALL be a sub-module sync_fifo (push/pop/full/empty/count); out_logger holds the FSM, change detection, and overflow.

Verification
REQ-032 Reset, hold out=5; then out 5→7 at addr 0x03 → one entry, rd_data=0x0307, count=1, and no entry for the initial 5.
REQ-033 With rd_ready=0, drive 9 distinct values → count=8, full=1, overflow=1 after the 9th; popping yields the first 8 in order.
REQ-034 Full FIFO, rd_ready=1, new value on the same edge → count stays 8, overflow stays 0, and the new entry appears last.
REQ-035 Hold out constant for 20 cycles in RUN → no pushes, count=0.
REQ-036 With 3 entries queued, assert rst for 1 cycle and change out on the next cycle → count=0 and no push (SEED); a change one cycle later pushes.
REQ-037 rd_ready toggling every cycle over 20 pushes → pointer wrap with no loss or duplication; the consumer sequence equals the producer sequence.

Source files
------------

// File: rtl/out_logger_pkg.sv
// Shared defaults and state encoding for the output logger.
package out_logger_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 8;
  localparam int ENTRY_W_DEF = 2 * DATA_W_DEF;

  // SEED captures the first value after reset; RUN detects changes.
  typedef enum logic {
    SEED = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/out_logger_fifo.sv
// First-word fall-through FIFO; the occupancy count is the only full/empty source.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A pop frees a slot on the same edge, so a full FIFO may still accept.
  always_comb begin
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/out_logger.sv
// Logs every change of the CPU result bus as {address, value} into a FIFO.
module out_logger
  import out_logger_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      out,
  input  logic [DATA_W-1:0]      addr_out,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [2*DATA_W-1:0]    rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_last_val;
  logic              r_overflow;
  logic              w_push_req;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= SEED;
    else     r_state <= w_state_nxt;
  end

  // One SEED cycle, then change detection in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    case (r_state)
      SEED: w_state_nxt = RUN;
      RUN:  w_push_req  = (out != r_last_val);
      default: w_state_nxt = SEED;
    endcase
  end

  // Reference value follows out on the seed edge and on every change, even dropped ones.
  always_ff @(posedge clk) begin
    if (rst)                              r_last_val <= '0;
    else if (r_state == SEED || w_push_req) r_last_val <= out;
  end

  // Sticky drop flag: a change arrived while full with no pop to make room.
  always_ff @(posedge clk) begin
    if (rst)                                  r_overflow <= 1'b0;
    else if (w_push_req && w_full && !w_pop)  r_overflow <= 1'b1;
  end

  assign w_pop = rd_ready && !w_empty;

  sync_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .wdata ({addr_out, out}),
    .rdata (rd_data),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  assign rd_valid = !w_empty;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_out_logger.sv
// Directed bench with a scoreboard queue checked by an independent pop monitor.
module tb_out_logger;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  out = 8'h00;
  logic [7:0]  addr_out = 8'h00;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  logic [15:0] q[$];

  out_logger #(.DATA_W(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .out      (out),
    .addr_out (addr_out),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set the bus; if a push is expected, record the entry in the scoreboard.
  task automatic drive(input logic [7:0] v, input logic [7:0] a, input bit exp_push);
    out      = v;
    addr_out = a;
    if (exp_push) q.push_back({a, v});
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    step();
    chk("reset_overflow", overflow, 0);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid && ready.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h want none", rd_data);
      end else begin
        logic [15:0] e;
        e = q.pop_front();
        chk("pop_data", rd_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with out held at 5.
    out = 8'h05; addr_out = 8'h03;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();                       // SEED edge
    step();                       // RUN, unchanged value
    chk("no_seed_push", count, 0);

    // 5 -> 7 at address 3.
    drive(8'h07, 8'h03, 1);
    step();
    chk("first_count", count, 1);
    chk("first_valid", rd_valid, 1);
    chk("first_data", rd_data, 16'h0307);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("first_drain", empty, 1);

    // Nine changes with no consumer: eighth fills, ninth drops.
    for (int i = 0; i < 9; i++) begin
      drive(8'h10 + 8'(i), 8'(i), i < 8);
      step();
      if (i == 7) chk("fill_ovf_clear", overflow, 0);
    end
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);
    chk("ovf_set", overflow, 1);
    rd_ready = 1'b1;
    repeat (8) step();
    rd_ready = 1'b0;
    chk("ovf_drain_count", count, 0);
    chk("ovf_drain_q", q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // Full FIFO with pop and push on the same edge.
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive(8'h20 + 8'(i), 8'h40 + 8'(i), 1);
      step();
    end
    chk("pp_full", full, 1);
    drive(8'h99, 8'h55, 1);
    rd_ready = 1'b1;
    step();
    chk("pp_count", count, 8);
    chk("pp_ovf", overflow, 0);
    repeat (8) step();
    rd_ready = 1'b0;
    chk("pp_empty", empty, 1);
    chk("pp_q", q.size(), 0);

    // Constant bus: no pushes.
    repeat (20) step();
    chk("hold_count", count, 0);

    // Reset mid-operation, change during SEED is ignored.
    for (int i = 0; i < 3; i++) begin
      drive(8'h30 + 8'(i), 8'h70 + 8'(i), 1);
      step();
    end
    chk("mid_count", count, 3);
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    drive(8'h3a, 8'h7a, 0);
    step();
    chk("seed_count", count, 0);
    chk("seed_valid", rd_valid, 0);
    drive(8'h3b, 8'h7b, 1);
    step();
    chk("post_seed_count", count, 1);
    chk("post_seed_data", rd_data, 16'h7b3b);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("post_seed_empty", empty, 1);

    // Twenty pushes with toggling ready: pointers wrap.
    for (int i = 0; i < 40; i++) begin
      rd_ready = i[0];
      if (i[0] == 1'b0) drive(8'h60 + 8'(i / 2), 8'h80 + 8'(i / 2), 1);
      step();
    end
    rd_ready = 1'b1;
    repeat (4) step();
    rd_ready = 1'b0;
    chk("wrap_q", q.size(), 0);
    chk("wrap_count", count, 0);
    chk("wrap_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
